ysyx_23060171_gpr_dump: RTL and testbench



---
 rtl/ysyx_23060171_gpr_dump.sv | 148 ++++++++++++++
 tb/tb_ysyx_23060171_gpr_dump.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060171_gpr_dump.sv
// ---------------------------------------------------------------------------
// ysyx_23060171_gpr_dump
//
// Sequential GPR snapshot reader. A start pulse in IDLE walks the register
// file through one combinational read port, one register at a time. Each word
// goes out on a valid/ready stream, tagged with its index and a last flag.
// An XOR checksum of every transferred word is kept for the debug side.
//
// Ports:
//   clk        - system clock, all state on the rising edge
//   rst        - asynchronous active-high reset
//   start      - one-cycle dump request, only looked at in IDLE
//   abort      - cancel a dump in progress (no done pulse)
//   busy       - high whenever the engine is not IDLE
//   done       - one-cycle pulse after the final word transfers
//   gpr_raddr  - read address to the GPR read port (idx in FETCH, else 0)
//   gpr_rdata  - combinational read data from the GPR
//   out_valid  - stream word valid
//   out_ready  - stream consumer ready
//   out_data   - register value being presented
//   out_idx    - register index of out_data
//   out_last   - out_data belongs to the all-ones index
//   checksum   - XOR of all words transferred in the current/last dump
// ---------------------------------------------------------------------------
module ysyx_23060171_gpr_dump #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter bit SKIP_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] gpr_raddr,
  input  logic [DATA_WIDTH-1:0] gpr_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST  = {ADDR_WIDTH{1'b1}};
  // x0 is hardwired zero in the GPR, so it is normally not worth streaming.
  localparam logic [ADDR_WIDTH-1:0] IDX_FIRST = SKIP_ZERO ? IDX_ONE : '0;

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] idx_q,      idx_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_idx_q,  out_idx_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    checksum_d = checksum_q;
    done       = 1'b0;
    out_valid  = 1'b0;
    gpr_raddr  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d      = IDX_FIRST;
          checksum_d = '0;
          state_d    = S_FETCH;
        end
      end

      S_FETCH: begin
        // The word is captured in its own FETCH cycle; a GPR write landing on
        // this same edge is therefore not seen.
        gpr_raddr  = idx_q;
        out_data_d = gpr_rdata;
        out_idx_d  = idx_q;
        out_last_d = (idx_q == IDX_LAST);
        state_d    = abort ? S_IDLE : S_SEND;
      end

      S_SEND: begin
        out_valid = 1'b1;
        // Abort wins over a same-cycle handshake: the word is dropped and the
        // checksum keeps its partial value.
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          checksum_d = checksum_q ^ out_data_q;
          if (out_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        // An abort arriving in the completion cycle suppresses the pulse.
        done    = ~abort;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign out_data = out_data_q;
  assign out_idx  = out_idx_q;
  assign out_last = out_last_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_ysyx_23060171_gpr_dump.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060171_gpr_dump
//
// Two instances: one with SKIP_ZERO=1, one with SKIP_ZERO=0. Only one is
// started at a time; use_s0 selects which one is stimulated and observed.
// The GPR is a plain array with a combinational read and writes landing on a
// clock edge. The reference model is transaction level: the expected word
// sequence comes from the index range and the GPR contents, the checksum is a
// running XOR, and the done cycle is 2 cycles per word plus one per stall
// plus one, counted from the edge that samples start.
// ---------------------------------------------------------------------------
module tb_ysyx_23060171_gpr_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        out_ready;
  logic        use_s0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] gpr_mem [32];
  logic [31:0] gpr_ref [32];

  logic        busy_s1, done_s1, valid_s1, last_s1;
  logic [4:0]  raddr_s1, idx_s1;
  logic [31:0] rdata_s1, data_s1, cs_s1;
  logic        busy_s0, done_s0, valid_s0, last_s0;
  logic [4:0]  raddr_s0, idx_s0;
  logic [31:0] rdata_s0, data_s0, cs_s0;

  logic        busy, done, out_valid, out_last;
  logic [4:0]  gpr_raddr, out_idx;
  logic [31:0] out_data, checksum;

  int errors;
  int checks;
  int cyc;

  assign rdata_s1 = gpr_mem[raddr_s1];
  assign rdata_s0 = gpr_mem[raddr_s0];

  assign busy      = use_s0 ? busy_s0  : busy_s1;
  assign done      = use_s0 ? done_s0  : done_s1;
  assign out_valid = use_s0 ? valid_s0 : valid_s1;
  assign out_last  = use_s0 ? last_s0  : last_s1;
  assign gpr_raddr = use_s0 ? raddr_s0 : raddr_s1;
  assign out_idx   = use_s0 ? idx_s0   : idx_s1;
  assign out_data  = use_s0 ? data_s0  : data_s1;
  assign checksum  = use_s0 ? cs_s0    : cs_s1;

  ysyx_23060171_gpr_dump #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1'b1)) u_dut_s1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start & ~use_s0),
    .abort     (abort),
    .busy      (busy_s1),
    .done      (done_s1),
    .gpr_raddr (raddr_s1),
    .gpr_rdata (rdata_s1),
    .out_valid (valid_s1),
    .out_ready (out_ready),
    .out_data  (data_s1),
    .out_idx   (idx_s1),
    .out_last  (last_s1),
    .checksum  (cs_s1)
  );

  ysyx_23060171_gpr_dump #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SKIP_ZERO(1'b0)) u_dut_s0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start & use_s0),
    .abort     (abort),
    .busy      (busy_s0),
    .done      (done_s0),
    .gpr_raddr (raddr_s0),
    .gpr_rdata (rdata_s0),
    .out_valid (valid_s0),
    .out_ready (out_ready),
    .out_data  (data_s0),
    .out_idx   (idx_s0),
    .out_last  (last_s0),
    .checksum  (cs_s0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Advance one clock; GPR writes land on the edge, outputs are observed 1ns
  // later so cyc names the cycle that has just begun.
  task automatic applyStimulus();
    @(posedge clk);
    if (wr_en) gpr_mem[wr_addr] = wr_data;
    #1;
    cyc++;
  endtask

  task automatic preload(input bit randomize_data);
    for (int i = 0; i < 32; i++) begin
      gpr_ref[i] = randomize_data ? $urandom : 32'h100 + i;
    end
    gpr_ref[0] = 32'h0;
    for (int i = 0; i < 32; i++) gpr_mem[i] = gpr_ref[i];
  endtask

  // One dump driven from start to completion (or abort). Negative indices
  // disable the corresponding event.
  task automatic runDump(input bit s0, input int stall_idx, input int stall_len,
                         input bit rand_ready, input int abort_idx,
                         input int restart_idx, input int write_at_idx,
                         input int write_reg, input logic [31:0] write_val);
    int          exp_idx;
    int          words;
    int          stalls;
    int          stall_left;
    int          exp_words;
    bit          fresh;
    bit          finished;
    bit          aborted;
    logic [31:0] cs;
    logic [31:0] held_data;

    use_s0     = s0;
    exp_idx    = s0 ? 0 : 1;
    exp_words  = 32 - exp_idx;
    words      = 0;
    stalls     = 0;
    stall_left = stall_len;
    fresh      = 1'b1;
    finished   = 1'b0;
    aborted    = 1'b0;
    cs         = 32'h0;
    held_data  = 32'h0;
    cyc        = 0;
    start      = 1'b1;
    abort      = 1'b0;
    out_ready  = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("start_busy", {31'h0, busy}, 32'h1);
    checkOutput("start_cs_cleared", checksum, 32'h0);
    checkOutput("first_raddr", {27'h0, gpr_raddr}, exp_idx);

    while (!finished && !aborted && cyc < 400) begin
      start = 1'b0;
      abort = 1'b0;
      wr_en = 1'b0;
      if (out_valid) begin
        if (fresh) begin
          checkOutput("word_idx", {27'h0, out_idx}, exp_idx);
          checkOutput("word_data", out_data, gpr_ref[exp_idx]);
          checkOutput("word_last", {31'h0, out_last}, (exp_idx == 31) ? 32'h1 : 32'h0);
          held_data = gpr_ref[exp_idx];
          if (exp_idx == restart_idx) start = 1'b1;
          if (exp_idx == write_at_idx) begin
            wr_en            = 1'b1;
            wr_addr          = write_reg[4:0];
            wr_data          = write_val;
            gpr_ref[write_reg] = write_val;
          end
        end else begin
          checkOutput("stall_idx_hold", {27'h0, out_idx}, exp_idx);
          checkOutput("stall_data_hold", out_data, held_data);
        end
        if (rand_ready) begin
          out_ready = ($urandom_range(0, 2) != 0);
        end else if (exp_idx == stall_idx && stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
        end
        if (out_ready) begin
          if (exp_idx == abort_idx) begin
            abort   = 1'b1;
            aborted = 1'b1;
          end else begin
            cs = cs ^ held_data;
            words++;
            exp_idx++;
            fresh = 1'b1;
          end
        end else begin
          stalls++;
          fresh = 1'b0;
        end
      end else if (done) begin
        checkOutput("done_cycle", cyc, 2 * words + 1 + stalls);
        checkOutput("done_word_count", words, exp_words);
        checkOutput("done_checksum", checksum, cs);
        finished = 1'b1;
      end else begin
        checkOutput("fetch_raddr", {27'h0, gpr_raddr}, exp_idx);
      end
      applyStimulus();
    end

    abort     = 1'b0;
    wr_en     = 1'b0;
    out_ready = 1'b1;
    if (aborted) begin
      checkOutput("abort_valid_drop", {31'h0, out_valid}, 32'h0);
      checkOutput("abort_busy", {31'h0, busy}, 32'h0);
      checkOutput("abort_no_done", {31'h0, done}, 32'h0);
      checkOutput("abort_partial_cs", checksum, cs);
    end else if (finished) begin
      checkOutput("post_done_busy", {31'h0, busy}, 32'h0);
      checkOutput("post_done_pulse", {31'h0, done}, 32'h0);
      checkOutput("post_done_cs_hold", checksum, cs);
    end else begin
      checkOutput("dump_timeout", cyc, 0);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    out_ready = 1'b1;
    use_s0  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 5'h0;
    wr_data = 32'h0;
    preload(1'b0);

    // Reset values.
    #2;
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_done", {31'h0, done}, 32'h0);
    checkOutput("rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_last", {31'h0, out_last}, 32'h0);
    checkOutput("rst_data", out_data, 32'h0);
    checkOutput("rst_idx", {27'h0, out_idx}, 32'h0);
    checkOutput("rst_raddr", {27'h0, gpr_raddr}, 32'h0);
    checkOutput("rst_checksum", checksum, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full dump, SKIP_ZERO=1");
    runDump(1'b0, -1, 0, 1'b0, -1, -1, -1, 0, 32'h0);
    checkOutput("skip1_cs_value", checksum, 32'h0000_0100);

    $display("[TB] full dump, SKIP_ZERO=0");
    runDump(1'b1, -1, 0, 1'b0, -1, -1, -1, 0, 32'h0);

    $display("[TB] backpressure on idx 5");
    runDump(1'b0, 5, 5, 1'b0, -1, -1, -1, 0, 32'h0);
    checkOutput("stall_cs_value", checksum, 32'h0000_0100);

    $display("[TB] abort on idx 10 handshake");
    runDump(1'b0, -1, 0, 1'b0, 10, -1, -1, 0, 32'h0);
    checkOutput("abort_cs_value", checksum, 32'h0000_0101);
    applyStimulus();
    checkOutput("abort_idle_no_done", {31'h0, done}, 32'h0);
    runDump(1'b0, -1, 0, 1'b0, -1, -1, -1, 0, 32'h0);

    $display("[TB] start while busy, GPR write ahead of fetch");
    runDump(1'b0, -1, 0, 1'b0, -1, 7, 12, 20, 32'hDEAD_BEEF);

    $display("[TB] randomized contents and backpressure");
    for (int r = 0; r < 3; r++) begin
      preload(1'b1);
      runDump(r[0], -1, 0, 1'b1, -1, -1, -1, 0, 32'h0);
    end

    $display("[TB] asynchronous reset mid-SEND");
    preload(1'b0);
    use_s0    = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int k = 0; k < 20 && !(out_valid && out_idx >= 5'd3); k++) applyStimulus();
    checkOutput("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("async_rst_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("async_rst_done", {31'h0, done}, 32'h0);
    checkOutput("async_rst_cs", checksum, 32'h0);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus();
      checkOutput("post_rst_quiet", {30'h0, out_valid, done}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
